// File: rtl/wm8731_dac_serializer.sv
// I2S master serializer for the WM8731 DAC: pops one stereo word per frame from the playback FIFO.
// Defining WM8731_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module wm8731_dac_serializer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned BCLK_DIV     = 2
) (
  input  logic                      Clk,
  input  logic                      Reset_in,
  input  logic                      Enable_in,
  input  logic [2*SAMPLE_WIDTH-1:0] Data_in,
  input  logic                      Empty_in,
  output logic                      ReadEn_out,
  output logic                      BClk_out,
  output logic                      DACLRC_out,
  output logic                      DACDAT_out,
  output logic                      Underrun_out,
`ifdef WM8731_UNDERRUN_CNT_EN
  output logic [7:0]                Underrun_cnt_out,
`endif
  output logic                      Running_out
);

  localparam int unsigned CNT_W      = $clog2(2 * SLOT_BITS);
  localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned IDX_W      = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam int unsigned FRAME_LAST = 2 * SLOT_BITS - 1;

  if (SLOT_BITS < SAMPLE_WIDTH + 1) begin : g_bad_slot
    $error("SLOT_BITS must be at least SAMPLE_WIDTH+1");
  end
  if (BCLK_DIV < 1) begin : g_bad_div
    $error("BCLK_DIV must be at least 1");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_W-1:0]        bit_q, bit_d;
  logic                    bclk_q, bclk_d;
  logic                    lrc_q, lrc_d;
  logic                    dat_q, dat_d;
  logic                    rd_q, rd_d;
  logic                    und_q, und_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;

  logic                    frame_start;
  logic                    right_slot;
  logic [CNT_W-1:0]        bit_nxt;
  logic [CNT_W-1:0]        slot_pos;
  logic [IDX_W-1:0]        bit_idx;

  // State and output registers
  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      bclk_q  <= 1'b0;
      lrc_q   <= 1'b0;
      dat_q   <= 1'b0;
      rd_q    <= 1'b0;
      und_q   <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      lrc_q   <= lrc_d;
      dat_q   <= dat_d;
      rd_q    <= rd_d;
      und_q   <= und_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Next-state: BCLK divider, bit sequencing on falling ticks, frame start/stop
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    bclk_d      = bclk_q;
    lrc_d       = lrc_q;
    dat_d       = dat_q;
    rd_d        = 1'b0;
    und_d       = 1'b0;
    left_d      = left_q;
    right_d     = right_q;
    frame_start = 1'b0;
    right_slot  = 1'b0;
    slot_pos    = '0;
    bit_idx     = '0;
    bit_nxt     = bit_q + CNT_W'(1);

    case (state_q)
      S_IDLE: frame_start = Enable_in;
      S_RUN: begin
        if (div_q == DIV_W'(BCLK_DIV - 1)) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            if (bit_q == CNT_W'(FRAME_LAST)) begin
              if (Enable_in) begin
                frame_start = 1'b1;
              end else begin
                state_d = S_IDLE;
                bclk_d  = 1'b0;
                lrc_d   = 1'b0;
                dat_d   = 1'b0;
                bit_d   = '0;
              end
            end else begin
              // MSB lands one BCLK after the LRC edge (slot position 1)
              right_slot = (bit_nxt >= CNT_W'(SLOT_BITS));
              slot_pos   = right_slot ? bit_nxt - CNT_W'(SLOT_BITS) : bit_nxt;
              bit_idx    = IDX_W'(CNT_W'(SAMPLE_WIDTH) - slot_pos);
              bit_d      = bit_nxt;
              lrc_d      = right_slot;
              dat_d      = (slot_pos != '0) && (slot_pos <= CNT_W'(SAMPLE_WIDTH)) &&
                           (right_slot ? right_q[bit_idx] : left_q[bit_idx]);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_start) begin
      state_d = S_RUN;
      div_d   = '0;
      bit_d   = '0;
      bclk_d  = 1'b0;
      lrc_d   = 1'b0;
      dat_d   = 1'b0;
      if (Empty_in) begin
        left_d  = '0;
        right_d = '0;
        und_d   = 1'b1;
      end else begin
        left_d  = Data_in[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
        right_d = Data_in[SAMPLE_WIDTH-1:0];
        rd_d    = 1'b1;
      end
    end
  end

`ifdef WM8731_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q;

  // Saturating count of underrun frames
  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      ucnt_q <= 8'd0;
    end else if (und_q && (ucnt_q != 8'hFF)) begin
      ucnt_q <= ucnt_q + 8'd1;
    end
  end

  assign Underrun_cnt_out = ucnt_q;
`endif

  assign ReadEn_out   = rd_q;
  assign BClk_out     = bclk_q;
  assign DACLRC_out   = lrc_q;
  assign DACDAT_out   = dat_q;
  assign Underrun_out = und_q;
  assign Running_out  = (state_q == S_RUN);

endmodule

// File: tb/tb_wm8731_dac_serializer.sv
// Scoreboard bench: an I2S receiver model decodes each frame and compares it with queued expectations.
// Two instances: default parameters and BCLK_DIV=1/SLOT_BITS=17.
module tb_wm8731_dac_serializer;

  localparam int unsigned SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, en, empty;
  logic [31:0] data [2];
  wire  [1:0]  rd, bclk, lrc, dat, und, run;
`ifdef WM8731_UNDERRUN_CNT_EN
  wire  [7:0]  ucnt0, ucnt1;
`endif

  wm8731_dac_serializer #(.SAMPLE_WIDTH(16), .SLOT_BITS(32), .BCLK_DIV(2)) u_dut (
    .Clk(clk), .Reset_in(rst[0]), .Enable_in(en[0]), .Data_in(data[0]), .Empty_in(empty[0]),
    .ReadEn_out(rd[0]), .BClk_out(bclk[0]), .DACLRC_out(lrc[0]), .DACDAT_out(dat[0]),
    .Underrun_out(und[0]),
`ifdef WM8731_UNDERRUN_CNT_EN
    .Underrun_cnt_out(ucnt0),
`endif
    .Running_out(run[0])
  );

  wm8731_dac_serializer #(.SAMPLE_WIDTH(16), .SLOT_BITS(17), .BCLK_DIV(1)) u_dut_fast (
    .Clk(clk), .Reset_in(rst[1]), .Enable_in(en[1]), .Data_in(data[1]), .Empty_in(empty[1]),
    .ReadEn_out(rd[1]), .BClk_out(bclk[1]), .DACLRC_out(lrc[1]), .DACDAT_out(dat[1]),
    .Underrun_out(und[1]),
`ifdef WM8731_UNDERRUN_CNT_EN
    .Underrun_cnt_out(ucnt1),
`endif
    .Running_out(run[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] expq [2][$];
  logic [31:0] fifo [2][$];
  int          frames_done [2];
  int          pops [2];
  int          nbits [2];
  int          und_seen [2];
  int          since_rise [2];
  int          since_lrc [2];
  int          since_frame [2];
  int          tot_und [2];
  bit          collecting [2];
  bit          prev_bclk [2];
  bit          prev_lrc [2];
  bit          prev_run [2];
  bit          have_lrc [2];
  bit          per_bad [2];
  bit          lrc_bad [2];
  logic [63:0] got [2];

  function automatic int slot_of(input int i);
    return (i == 0) ? 32 : 17;
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic void check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got_v, exp_v);
    end
  endfunction

  // Serial bit k of an I2S frame: MSB-first sample starting at slot position 1, zero padding elsewhere
  function automatic logic [63:0] exp_bits(input logic [31:0] word, input int slot);
    logic [63:0] r;
    logic [15:0] ch;
    r = '0;
    for (int k = 0; k < 2 * slot; k++) begin
      int p;
      p  = k % slot;
      ch = (k >= slot) ? word[15:0] : word[31:16];
      if (p >= 1 && p <= SW) r[k] = ch[SW-p];
    end
    return r;
  endfunction

`ifdef WM8731_UNDERRUN_CNT_EN
  function automatic logic [7:0] ucnt_of(input int i);
    return (i == 0) ? ucnt0 : ucnt1;
  endfunction
`endif

  // FIFO model: first-word-fall-through, refreshed away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (fifo[i].size() == 0);
      data[i]  = empty[i] ? 32'hDEADBEEF : fifo[i][0];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd[i] === 1'b1) begin
        check($sformatf("i%0d_pop_nonempty", i), 64'(fifo[i].size() != 0), 64'd1);
        if (fifo[i].size() != 0) void'(fifo[i].pop_front());
        pops[i]++;
      end
    end
  end

  // I2S receiver: captures DACDAT on BCLK rising edges, frames delimited by run start or LRC fall
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        if (collecting[i] && expq[i].size() != 0) void'(expq[i].pop_front());
        collecting[i] = 0;
        have_lrc[i]   = 0;
        prev_bclk[i]  = 0;
        prev_lrc[i]   = 0;
        prev_run[i]   = 0;
      end else begin
        if (run[i] && !prev_run[i]) begin
          since_lrc[i]   = 0;
          since_frame[i] = 0;
          have_lrc[i]    = 1;
        end
        if (!run[i]) have_lrc[i] = 0;
        if (run[i] && prev_run[i] && (lrc[i] != prev_lrc[i])) begin
          if (have_lrc[i])
            check($sformatf("i%0d_lrc_interval", i), 64'(since_lrc[i]), 64'(2 * slot_of(i) * div_of(i)));
          since_lrc[i] = 0;
          have_lrc[i]  = 1;
          if (!lrc[i]) begin
            check($sformatf("i%0d_frame_len", i), 64'(since_frame[i]), 64'(4 * slot_of(i) * div_of(i)));
            since_frame[i] = 0;
          end
        end
        if (run[i] && (!prev_run[i] || (prev_lrc[i] && !lrc[i]))) begin
          check($sformatf("i%0d_prev_frame_complete", i), 64'(collecting[i]), 64'd0);
          collecting[i] = 1;
          nbits[i]      = 0;
          und_seen[i]   = 0;
          per_bad[i]    = 0;
          lrc_bad[i]    = 0;
          got[i]        = '0;
        end
        if (und[i]) und_seen[i]++;
        if (collecting[i] && bclk[i] && !prev_bclk[i]) begin
          if (nbits[i] > 0 && since_rise[i] != 2 * div_of(i)) per_bad[i] = 1;
          since_rise[i] = 0;
          if (lrc[i] != (nbits[i] >= slot_of(i))) lrc_bad[i] = 1;
          got[i][nbits[i]] = dat[i];
          nbits[i]++;
          if (nbits[i] == 2 * slot_of(i)) begin
            collecting[i] = 0;
            frames_done[i]++;
            if (expq[i].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL i%0d_scoreboard: frame received with no expected entry", i);
            end else begin
              logic [32:0] e;
              e = expq[i].pop_front();
              check($sformatf("i%0d_frame_bits", i), got[i], exp_bits(e[32] ? 32'h0 : e[31:0], slot_of(i)));
              check($sformatf("i%0d_underrun_pulses", i), 64'(und_seen[i]), 64'(e[32]));
              check($sformatf("i%0d_bclk_period_bad", i), 64'(per_bad[i]), 64'd0);
              check($sformatf("i%0d_lrc_level_bad", i), 64'(lrc_bad[i]), 64'd0);
            end
          end
        end
        since_rise[i]++;
        since_lrc[i]++;
        since_frame[i]++;
        prev_bclk[i] = bclk[i];
        prev_lrc[i]  = lrc[i];
        prev_run[i]  = run[i];
      end
    end
  end

  task automatic check_idle(input int i, input string tag);
    check($sformatf("i%0d_%s_idle_outputs", i, tag),
          64'({rd[i], bclk[i], lrc[i], dat[i], und[i], run[i]}), 64'd0);
  endtask

  // Queue n_words (then n_und underrun frames), run exactly that many frames, drop Enable mid-last-frame
  task automatic run_frames(input int i, input int n_words, input int n_und,
                            input logic [31:0] first_word, input bit use_first);
    int base, pops0, total, guard;
    logic [31:0] w;
    base  = frames_done[i];
    pops0 = pops[i];
    total = n_words + n_und;
    for (int k = 0; k < n_words; k++) begin
      w = (k == 0 && use_first) ? first_word : 32'($urandom());
      fifo[i].push_back(w);
      expq[i].push_back({1'b0, w});
    end
    for (int k = 0; k < n_und; k++) expq[i].push_back({1'b1, 32'h0});
    tot_und[i] += n_und;
    repeat (2) @(negedge clk);
    en[i] = 1'b1;
    guard = 0;
    while (!(frames_done[i] == base + total - 1 && collecting[i] && nbits[i] >= 10) &&
           guard < total * 300 + 200) begin
      @(negedge clk);
      guard++;
    end
    en[i] = 1'b0;
    guard = 0;
    while ((run[i] !== 1'b0 || frames_done[i] != base + total) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check($sformatf("i%0d_frames", i), 64'(frames_done[i] - base), 64'(total));
    check($sformatf("i%0d_pops", i), 64'(pops[i] - pops0), 64'(n_words));
    check($sformatf("i%0d_fifo_left", i), 64'(fifo[i].size()), 64'd0);
    check($sformatf("i%0d_expected_left", i), 64'(expq[i].size()), 64'd0);
    check_idle(i, "after_run");
`ifdef WM8731_UNDERRUN_CNT_EN
    check($sformatf("i%0d_underrun_cnt", i), 64'(ucnt_of(i)), 64'((tot_und[i] > 255) ? 255 : tot_und[i]));
`endif
  endtask

  // Reset during the right slot, then a fresh frame with a new pop after release
  task automatic reset_mid_frame();
    int base, pops0, guard;
    logic [31:0] wa, wb;
    wa = 32'($urandom());
    wb = 32'($urandom());
    fifo[0].push_back(wa);
    expq[0].push_back({1'b0, wa});
    fifo[0].push_back(wb);
    expq[0].push_back({1'b0, wb});
    repeat (2) @(negedge clk);
    en[0] = 1'b1;
    guard = 0;
    while (!(collecting[0] && nbits[0] >= 40) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("i0_reached_right_slot", 64'(lrc[0]), 64'd1);
    #2 rst[0] = 1'b1;
    #1 check_idle(0, "async_reset");
    tot_und[0] = 0;
    repeat (3) @(negedge clk);
    base  = frames_done[0];
    pops0 = pops[0];
    rst[0] = 1'b0;
    guard = 0;
    while (!(frames_done[0] == base && collecting[0] && nbits[0] >= 10) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    en[0] = 1'b0;
    guard = 0;
    while ((run[0] !== 1'b0 || frames_done[0] != base + 1) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("i0_post_reset_frames", 64'(frames_done[0] - base), 64'd1);
    check("i0_post_reset_pops", 64'(pops[0] - pops0), 64'd1);
    check("i0_post_reset_fifo_left", 64'(fifo[0].size()), 64'd0);
    check("i0_post_reset_expected_left", 64'(expq[0].size()), 64'd0);
    check_idle(0, "after_reset_run");
  endtask

  initial begin
    rst   = 2'b11;
    en    = 2'b00;
    empty = 2'b11;
    data[0] = 32'h0;
    data[1] = 32'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_idle(i, "reset");
`ifdef WM8731_UNDERRUN_CNT_EN
      check($sformatf("i%0d_reset_underrun_cnt", i), 64'(ucnt_of(i)), 64'd0);
`endif
    end
    rst = 2'b00;
    fork
      begin
        run_frames(0, 1, 0, 32'hA5A53C3C, 1'b1);
        run_frames(0, 0, 1, 32'h0, 1'b0);
        run_frames(0, 3, 2, 32'h0, 1'b0);
        run_frames(0, 4, 0, 32'h0, 1'b0);
        reset_mid_frame();
`ifdef WM8731_UNDERRUN_CNT_EN
        run_frames(0, 0, 300, 32'h0, 1'b0);
`endif
      end
      begin
        run_frames(1, 1, 0, 32'hA5A53C3C, 1'b1);
        run_frames(1, 3, 1, 32'h0, 1'b0);
        run_frames(1, 2, 0, 32'h0, 1'b0);
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
